// File: rtl/vault_seq_lock.sv
// vault_seq_lock: parametrised sequence lock; symbols over valid/ready are checked against a key latched at arm time, with retry counting, lockout and a done hand-off
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      arm pulse: latch key_in, enter ARMED (re-arms from ARMED and DONE)
//   clear      synchronous return to IDLE, beats start and symbol acceptance
//   key_in     expected sequence, symbol i at [i*SYM_W +: SYM_W]
//   sym_in     entered symbol, qualified by sym_valid
//   sym_ready  high in ARMED
//   progress   correctly matched symbols so far
//   fail_cnt   mismatches since arm or last lockout
//   err_pulse  one-cycle pulse per mismatch
//   locked_out high for exactly LOCKOUT_CYC cycles after MAX_TRIES mismatches
//   done       sequence fully matched
// Optional: define VAULT_SEQ_TIMEOUT_EN to treat TIMEOUT_CYC idle cycles mid-sequence as a mismatch.
module vault_seq_lock #(
    parameter int SYM_W       = 3,
    parameter int SEQ_LEN     = 5,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int TIMEOUT_CYC = 32,
    localparam int IDX_W      = $clog2(SEQ_LEN + 1),
    localparam int FAIL_W     = $clog2(MAX_TRIES + 1),
    localparam int LCK_W      = $clog2(LOCKOUT_CYC + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clear,
    input  logic [SEQ_LEN*SYM_W-1:0] key_in,
    input  logic [SYM_W-1:0]         sym_in,
    input  logic                     sym_valid,
    output logic                     sym_ready,
    output logic [IDX_W-1:0]         progress,
    output logic [FAIL_W-1:0]        fail_cnt,
    output logic                     err_pulse,
    output logic                     locked_out,
    output logic                     done
);
    typedef enum logic [1:0] {IDLE, ARMED, LOCKOUT, DONE} state_t;
    state_t                   state, state_d;
    logic [SEQ_LEN*SYM_W-1:0] key_q, key_d;
    logic [IDX_W-1:0]         prog_d;
    logic [FAIL_W-1:0]        fail_d, fail_inc;
    logic                     err_d;
    logic [LCK_W-1:0]         lck_q, lck_d;
    logic [SYM_W-1:0]         key_sym;
    logic                     accept;
    logic                     tmo_hit;
    assign sym_ready  = state == ARMED;
    assign locked_out = state == LOCKOUT;
    assign done       = state == DONE;
    assign accept     = sym_valid && state == ARMED;
    assign key_sym    = key_q[progress*SYM_W +: SYM_W];
    assign fail_inc   = fail_cnt + 1'b1;
`ifdef VAULT_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign tmo_hit = state == ARMED && progress != '0 && tmo_q == TMO_W'(TIMEOUT_CYC - 1);
    // counts idle cycles mid-sequence; zero on accept, on (re)arm and while progress is 0
    assign tmo_d   = (state == ARMED && !clear && !start && !accept && !tmo_hit && progress != '0)
                   ? tmo_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
`else
    assign tmo_hit = 1'b0;
`endif
    always_comb begin
        state_d = state;
        key_d   = key_q;
        prog_d  = progress;
        fail_d  = fail_cnt;
        err_d   = 1'b0;
        lck_d   = lck_q;
        if (clear) begin
            state_d = IDLE;
            prog_d  = '0;
            fail_d  = '0;
            lck_d   = '0;
        end else begin
            case (state)
                IDLE:
                    if (start) begin
                        state_d = ARMED;
                        key_d   = key_in;
                        prog_d  = '0;
                        fail_d  = '0;
                    end
                ARMED:
                    // a re-arm drops any symbol offered on the same edge
                    if (start) begin
                        key_d  = key_in;
                        prog_d = '0;
                    end else if (accept && sym_in == key_sym) begin
                        prog_d  = progress + 1'b1;
                        state_d = progress == IDX_W'(SEQ_LEN - 1) ? DONE : ARMED;
                    end else if (accept || tmo_hit) begin
                        prog_d  = '0;
                        err_d   = 1'b1;
                        fail_d  = fail_inc;
                        state_d = fail_inc == FAIL_W'(MAX_TRIES) ? LOCKOUT : ARMED;
                        lck_d   = LCK_W'(LOCKOUT_CYC - 1);
                    end
                LOCKOUT:
                    if (lck_q == '0) begin
                        state_d = ARMED;
                        fail_d  = '0;
                        prog_d  = '0;
                    end else begin
                        lck_d = lck_q - 1'b1;
                    end
                DONE:
                    if (start) begin
                        state_d = ARMED;
                        key_d   = key_in;
                        prog_d  = '0;
                    end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            key_q     <= '0;
            progress  <= '0;
            fail_cnt  <= '0;
            err_pulse <= 1'b0;
            lck_q     <= '0;
        end else begin
            state     <= state_d;
            key_q     <= key_d;
            progress  <= prog_d;
            fail_cnt  <= fail_d;
            err_pulse <= err_d;
            lck_q     <= lck_d;
        end
    end
endmodule
